boot_loader: RTL
================

# boot_loader

Synthesizable program preloader for the RV32I core. It zero-fills a configurable region of the byte-lane memory, then streams an image in one byte at a time from a valid/ready byte source. Byte n goes to lane n mod LANES of word BASE_WORD + n/LANES. It holds the core in reset until the load completes and reports an 8-bit checksum. It sits between a host byte link (UART/JTAG bridge) and the memory's per-lane write ports, replacing bench-only preloading.

## Interface
- LANES, 4: byte lanes per memory word; data width is 8*LANES.
- ADDR_W, 20: word-address width.
- LEN_W, 20: width of the byte-count input.
- BASE_WORD, 0: first word address written by LOAD.
- CLEAR_WORDS, 64: words zeroed from address 0 before LOAD; 0 disables CLEAR.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- len  in  LEN_W  image length in bytes; captured with start.
- s_valid  in  1  byte source has data.
- s_data  in  8  byte from source.
- s_ready  out  1  loader accepts s_data this cycle.
- mem_we  out  LANES  per-lane write enable; one bit per lane memory.
- mem_addr  out  ADDR_W  word address, shared by all lanes.
- mem_wdata  out  8*LANES  write data; lane k occupies bits [8k+7:8k].
- core_rst_n  out  1  active-low reset to the core; low while not DONE.
- busy  out  1  high in CLEAR or LOAD.
- done  out  1  high in DONE.
- checksum  out  8  modulo-256 sum of all bytes accepted in the current load.

## Operation
- States: IDLE, CLEAR, LOAD, DONE.
- Reset values:
  - state IDLE.
  - s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - core_rst_n 0, busy 0, done 0, checksum 0.
- IDLE + start: capture len and clear checksum and byte counter.
  - Go to CLEAR if CLEAR_WORDS > 0.
  - Otherwise go to LOAD if len > 0, else go to DONE.
- CLEAR:
  - One word per cycle, addresses 0 .. CLEAR_WORDS-1.
  - mem_we all ones, mem_wdata 0.
  - After the last word: go to LOAD if len > 0, else go to DONE.
- LOAD:
  - s_ready = 1. A byte is accepted when s_valid & s_ready.
  - The accepted byte is written the next cycle:
    - mem_we has a single bit set, lane = cnt mod LANES.
    - mem_addr = (BASE_WORD + cnt/LANES) mod 2^ADDR_W.
    - The byte is placed in its lane; other lanes of mem_wdata are 0.
  - cnt increments and checksum += byte (mod 256).
  - When the accepted byte brings cnt to len: deassert s_ready the same cycle, and go to DONE after that byte's write cycle.
- DONE:
  - done = 1 and core_rst_n = 1; holds until reset or start.
  - start in DONE starts a new load exactly as from IDLE. core_rst_n drops low in the first cycle after start is sampled.
- start while busy is ignored. len is not re-captured.
- Address arithmetic wraps modulo 2^ADDR_W. There is no overflow error.
- LANES must be a power of two. Lane index and word offset come from cnt bits, with no divider.
- mem_we is nonzero only in CLEAR and in LOAD write cycles. mem_we is 0 in IDLE, DONE and idle LOAD cycles.

## Timing
- All outputs are registered; no combinational path from s_valid to s_ready.
- start in cycle t → first CLEAR write (or LOAD s_ready=1) in cycle t+1.
- CLEAR lasts exactly CLEAR_WORDS cycles.
- Byte accepted at edge t → mem_we/mem_addr/mem_wdata valid in cycle t+1.
- Full-rate stream: one byte per cycle, so LOAD lasts len cycles plus 1 flush cycle.
- Last byte accepted at edge t → write in t+1 → done = 1 and core_rst_n = 1 from t+2.
- len = 0 with CLEAR_WORDS = 0: start at t → done at t+1.
- s_valid low stalls LOAD indefinitely, with no timeout.
- rst_n asserted mid-CLEAR or mid-LOAD:
  - Return immediately to the reset values.
  - No further writes; memory keeps any partial contents.
  - core_rst_n stays low.

## Test plan
- Full-rate load:
  - Stimulus: LANES=4, CLEAR_WORDS=0, len=264, bytes i&0xFF streamed at full rate.
  - Required: 264 single-lane writes; word 65 lanes = 0x04,0x05,0x06,0x07; checksum equals the modulo-256 sum of the 264 bytes; done at cycle 266 after start.
- Clear then load:
  - Stimulus: CLEAR_WORDS=8, memory preset to 0xFFFFFFFF, len=6.
  - Required: words 0..7 zeroed with mem_we=4'b1111; then words 0..1 show bytes 0..5; word 1 lanes 2..3 remain 0.
- Backpressure:
  - Stimulus: len=10, s_valid toggled 1,0,0,1,...
  - Required: exactly 10 writes, no write in gap cycles, correct lane sequence 0,1,2,3,0,..., s_ready falls after the 10th byte.
- Zero length and restart:
  - Stimulus: len=0 → done=1, core_rst_n=1; then start with len=4.
  - Required: core_rst_n=0 the cycle after start; 4 bytes land at BASE_WORD; done again.
- Ignored start and reset:
  - Stimulus: start pulsed mid-LOAD with a different len.
  - Required: the original len is completed.
  - Stimulus: rst_n low after byte 3.
  - Required: all outputs at reset values; no further mem_we.
- Wrap:
  - Stimulus: ADDR_W=4, BASE_WORD=15, len=8.
  - Required: bytes 0..3 written to word 15, bytes 4..7 to word 0.

Source files
------------

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Program preloader for the RV32I core. After a start request it optionally
// zero-fills words 0 .. CLEAR_WORDS-1 of the byte-lane memory, then accepts an
// image one byte at a time from a valid/ready byte source. Byte n is written to
// lane (n mod LANES) of word (BASE_WORD + n/LANES), wrapping at 2^ADDR_W. The
// core is held in reset until the load has completed. An 8-bit modulo-256
// checksum of the accepted bytes is reported.
//
// Parameters
//   LANES        byte lanes per memory word (power of two)
//   ADDR_W       word-address width
//   LEN_W        width of the byte-count input
//   BASE_WORD    first word address written during LOAD
//   CLEAR_WORDS  words zeroed from address 0 before LOAD (0 skips CLEAR)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle load request, honoured only in IDLE or DONE
//   len         image length in bytes, captured with start
//   s_valid     byte source has data
//   s_data      byte from source
//   s_ready     loader accepts s_data this cycle
//   mem_we      per-lane write enable
//   mem_addr    word address shared by all lanes
//   mem_wdata   write data, lane k in bits [8k+7:8k]
//   core_rst_n  active-low reset to the core, high only in DONE
//   busy        high in CLEAR or LOAD
//   done        high in DONE
//   checksum    modulo-256 sum of bytes accepted in the current load
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int LANES       = 4,
  parameter int ADDR_W      = 20,
  parameter int LEN_W       = 20,
  parameter int BASE_WORD   = 0,
  parameter int CLEAR_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic [LANES-1:0]     mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [8*LANES-1:0]   mem_wdata,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum
);

  // Lane index and word offset are plain bit fields of the byte counter
  // because LANES is a power of two.
  localparam int LSB_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int CLR_W = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [CLR_W-1:0] clr_cnt;

  // Decode of the write that an accepted byte produces.
  logic [LEN_W-1:0]   lane;
  logic [LANES-1:0]   lane_we;
  logic [8*LANES-1:0] lane_wdata;
  logic [ADDR_W-1:0]  word_addr;
  logic [LEN_W-1:0]   cnt_next;
  logic               accept;
  logic               last_byte;
  logic               clear_last;
  logic               start_ok;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path through it can leave a value held (no latch).
  always_comb begin
    lane       = '0;
    lane_we    = '0;
    lane_wdata = '0;
    word_addr  = '0;
    lane       = cnt & LEN_W'(LANES - 1);
    lane_we    = LANES'(1) << lane;
    lane_wdata = (8*LANES)'(s_data) << {lane, 3'b000};
    word_addr  = ADDR_W'(BASE_WORD) + ADDR_W'(cnt >> LSB_W);
  end

  assign cnt_next   = cnt + 1'b1;
  assign accept     = (state == ST_LOAD) && s_ready && s_valid;
  assign last_byte  = (cnt_next == len_q);
  assign clear_last = (clr_cnt == CLR_W'(CLEAR_WORDS - 1));
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));

  // NOTE: the reset branch covers only control and output registers; the
  // memory being loaded lives outside this block and keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      cnt        <= '0;
      clr_cnt    <= '0;
      s_ready    <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here sees the pre-edge value of every other one.
      // Write strobes are single-cycle pulses unless a branch below renews them.
      mem_we    <= '0;
      mem_wdata <= '0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            len_q      <= len;
            cnt        <= '0;
            clr_cnt    <= '0;
            checksum   <= '0;
            if (CLEAR_WORDS > 0) begin
              state      <= ST_CLEAR;
              busy       <= 1'b1;
              done       <= 1'b0;
              core_rst_n <= 1'b0;
              mem_we     <= '1;
              mem_addr   <= '0;
            end else if (len != '0) begin
              state      <= ST_LOAD;
              busy       <= 1'b1;
              done       <= 1'b0;
              core_rst_n <= 1'b0;
              s_ready    <= 1'b1;
            end else begin
              // Empty image without a clear phase: finished immediately.
              state      <= ST_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end
          end
        end

        ST_CLEAR: begin
          if (clear_last) begin
            if (len_q != '0) begin
              state   <= ST_LOAD;
              s_ready <= 1'b1;
            end else begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end
          end else begin
            clr_cnt  <= clr_cnt + 1'b1;
            mem_we   <= '1;
            mem_addr <= ADDR_W'(clr_cnt + 1'b1);
          end
        end

        ST_LOAD: begin
          if (s_ready) begin
            if (accept) begin
              mem_we    <= lane_we;
              mem_addr  <= word_addr;
              mem_wdata <= lane_wdata;
              cnt       <= cnt_next;
              checksum  <= checksum + s_data;
              // Stop accepting as soon as the final byte is taken; the
              // following cycle carries its write.
              if (last_byte) s_ready <= 1'b0;
            end
          end else begin
            // Flush cycle: the last byte's write is on the bus now.
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_rst_n <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
